// File: rtl/ariane_pkg.sv
// Branch resolution and prediction types, plus BHT entry type, reset value and counter update.
package ariane_pkg;
    typedef enum logic [2:0] {
        NoCF,
        Branch,
        Jump,
        JumpR,
        Return
    } cf_t;

    typedef struct packed {
        logic                    valid;
        logic [riscv::VLEN-1:0]  pc;
        logic [riscv::VLEN-1:0]  target_address;
        logic                    is_mispredict;
        logic                    is_taken;
        cf_t                     cf_type;
    } bp_resolve_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] cnt;
    } bht_entry_t;

    typedef enum logic {
        BHT_INIT,
        BHT_RUN
    } bht_state_e;

    localparam logic [1:0] BHT_CNT_RESET = 2'b01;

    function automatic logic [1:0] bht_sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    endfunction
endpackage

// File: rtl/riscv.sv
// Minimal RISC-V architectural constants used by the branch predictor slice.
package riscv;
    localparam int unsigned VLEN = 39;
endpackage

// File: rtl/bht_init_sequencer.sv
// INIT/RUN sequencer: walks clear_idx over every BHT entry after reset or flush.
module bht_init_sequencer
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 1024,
    localparam int unsigned IDX_W = $clog2(NR_ENTRIES)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    output logic             o_clear_we,
    output logic [IDX_W-1:0] o_clear_idx,
    output logic             o_init_done,
    output logic             o_state_dbg
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

    bht_state_e       r_state;
    bht_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_clear_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_clear_we;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= BHT_INIT;
            r_clear_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_clear_idx <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_clear_idx;
        w_clear_we  = 1'b0;
        case (r_state)
            BHT_INIT: begin
                w_clear_we = 1'b1;
                // A flush mid-clear restarts the walk; rows already cleared are simply cleared again.
                if (i_flush) begin
                    w_idx_nxt = '0;
                end else begin
                    w_idx_nxt = r_clear_idx + IDX_W'(1);
                    if (r_clear_idx == LAST_IDX) begin
                        w_state_nxt = BHT_RUN;
                    end
                end
            end
            BHT_RUN: begin
                if (i_flush) begin
                    w_state_nxt = BHT_INIT;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = BHT_INIT;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign o_clear_we  = w_clear_we;
    assign o_clear_idx = r_clear_idx;
    assign o_init_done = (r_state == BHT_RUN);
    assign o_state_dbg = r_state;
endmodule

// File: rtl/bht_resolve_unit.sv
// BHT of 2-bit saturating counters trained by resolved branches, read combinationally by the frontend.
// Optional macro BHT_BYPASS_EN forwards a same-cycle training write to a lookup of the same index.
module bht_resolve_unit
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 1024,
    parameter int unsigned VLEN       = riscv::VLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_bp_i,
    input  logic            debug_mode_i,
    input  logic [VLEN-1:0] vpc_i,
    output bht_prediction_t bht_prediction_o,
    input  bp_resolve_t     resolved_branch_i,
    output logic            init_done_o
);
    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

    bht_entry_t       r_bht [NR_ENTRIES];

    logic             w_clear_we;
    logic [IDX_W-1:0] w_clear_idx;
    logic             w_init_done;
    logic             w_state_dbg;
    logic [IDX_W-1:0] w_lookup_idx;
    logic [IDX_W-1:0] w_train_idx;
    logic             w_train_we;
    bht_entry_t       w_rd_entry;
    bht_entry_t       w_old_entry;
    bht_entry_t       w_train_entry;
    bht_prediction_t  w_pred;
    logic             w_unused;

    bht_init_sequencer #(
        .NR_ENTRIES (NR_ENTRIES)
    ) u_init_seq (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_flush     (flush_bp_i),
        .o_clear_we  (w_clear_we),
        .o_clear_idx (w_clear_idx),
        .o_init_done (w_init_done),
        .o_state_dbg (w_state_dbg)
    );

    // Bit 0 is never set on a legal PC; bit 1 distinguishes compressed instructions.
    assign w_lookup_idx = vpc_i[IDX_W:1];
    assign w_train_idx  = resolved_branch_i.pc[IDX_W:1];

    assign w_train_we = resolved_branch_i.valid && (resolved_branch_i.cf_type == Branch) &&
                        !debug_mode_i && w_init_done && !flush_bp_i && !rst_i;

    assign w_old_entry         = r_bht[w_train_idx];
    assign w_train_entry.valid = 1'b1;
    assign w_train_entry.cnt   = bht_sat_update(w_old_entry.valid ? w_old_entry.cnt : BHT_CNT_RESET,
                                                resolved_branch_i.is_taken);

    always_ff @(posedge clk_i) begin
        if (w_clear_we) begin
            r_bht[w_clear_idx] <= '{valid: 1'b0, cnt: BHT_CNT_RESET};
        end else if (w_train_we) begin
            r_bht[w_train_idx] <= w_train_entry;
        end
    end

    assign w_rd_entry = r_bht[w_lookup_idx];

    always_comb begin
        w_pred.valid = w_rd_entry.valid & w_init_done;
        w_pred.taken = w_rd_entry.cnt[1] & w_pred.valid;
`ifdef BHT_BYPASS_EN
        if (w_train_we && (w_train_idx == w_lookup_idx)) begin
            w_pred.valid = 1'b1;
            w_pred.taken = w_train_entry.cnt[1];
        end
`endif
    end

    assign bht_prediction_o = w_pred;
    assign init_done_o      = w_init_done;

    assign w_unused = ^{vpc_i[VLEN-1:IDX_W+1], vpc_i[0],
                        resolved_branch_i.pc[riscv::VLEN-1:IDX_W+1], resolved_branch_i.pc[0],
                        resolved_branch_i.target_address, resolved_branch_i.is_mispredict,
                        w_state_dbg};
endmodule

// File: tb/tb_bht_resolve_unit.sv
// Directed bench for bht_resolve_unit with 16 entries: table-driven training rows plus init/flush sequences.
module tb_bht_resolve_unit;
    import ariane_pkg::*;

    localparam int unsigned N  = 16;
    localparam int unsigned VL = riscv::VLEN;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_bp_i;
    logic            debug_mode_i;
    logic [VL-1:0]   vpc_i;
    bht_prediction_t bht_prediction_o;
    bp_resolve_t     resolved_branch_i;
    logic            init_done_o;

    int n_checks = 0;
    int n_fail   = 0;

    bht_resolve_unit #(
        .NR_ENTRIES (N),
        .VLEN       (VL)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .flush_bp_i        (flush_bp_i),
        .debug_mode_i      (debug_mode_i),
        .vpc_i             (vpc_i),
        .bht_prediction_o  (bht_prediction_o),
        .resolved_branch_i (resolved_branch_i),
        .init_done_o       (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [VL-1:0] pc;
        logic [VL-1:0] lpc;
        logic          rv;
        cf_t           cf;
        logic          tk;
        logic          dbg;
        logic          mis;
        logic          ev;
        logic          et;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic [VL-1:0] pc, input logic [VL-1:0] lpc, input logic rv,
                                input cf_t cf, input logic tk, input logic dbg, input logic mis,
                                input logic ev, input logic et);
        vec_t v;
        v.pc = pc; v.lpc = lpc; v.rv = rv; v.cf = cf; v.tk = tk;
        v.dbg = dbg; v.mis = mis; v.ev = ev; v.et = et;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_res(input logic v, input logic [VL-1:0] pc, input cf_t cf, input logic tk,
                             input logic mis);
        resolved_branch_i.valid          = v;
        resolved_branch_i.pc             = pc;
        resolved_branch_i.target_address = pc + VL'(64);
        resolved_branch_i.is_mispredict  = mis;
        resolved_branch_i.is_taken       = tk;
        resolved_branch_i.cf_type        = cf;
    endtask

    task automatic wait_clear(input string name);
        for (int i = 0; i < int'(N); i++) begin
            check({name, "_busy"}, {31'd0, init_done_o}, 32'd0);
            tick();
        end
        check({name, "_done"}, {31'd0, init_done_o}, 32'd1);
    endtask

    initial begin
        rst_i        = 1'b1;
        flush_bp_i   = 1'b0;
        debug_mode_i = 1'b0;
        vpc_i        = '0;
        drive_res(1'b0, '0, NoCF, 1'b0, 1'b0);

        vecs[0]  = mk(VL'(32'h8000_0010), VL'(32'h8000_0010), 1, Branch, 1, 0, 0, 1, 1);
        vecs[1]  = mk(VL'(32'h8000_0010), VL'(32'h8000_0010), 1, Branch, 1, 0, 0, 1, 1);
        vecs[2]  = mk(VL'(32'h8000_0010), VL'(32'h8000_0010), 1, Branch, 1, 0, 1, 1, 1);
        vecs[3]  = mk(VL'(32'h8000_0010), VL'(32'h8000_0010), 1, Branch, 0, 0, 1, 1, 1);
        vecs[4]  = mk(VL'(32'h8000_0010), VL'(32'h8000_0010), 1, Branch, 0, 0, 0, 1, 0);
        for (int i = 5; i < 11; i++) begin
            vecs[i] = mk(VL'(32'h20), VL'(32'h20), 1, Branch, 0, 0, 0, 1, 0);
        end
        vecs[11] = mk(VL'(32'h0), VL'(32'h40), 0, Branch, 0, 0, 0, 1, 0);
        vecs[12] = mk(VL'(32'h0), VL'(32'h30), 0, Branch, 0, 0, 0, 1, 0);
        vecs[13] = mk(VL'(32'h8), VL'(32'h8), 1, JumpR,  1, 0, 1, 0, 0);
        vecs[14] = mk(VL'(32'h8), VL'(32'h8), 1, Branch, 1, 1, 0, 0, 0);
        vecs[15] = mk(VL'(32'h8), VL'(32'h8), 1, Jump,   1, 0, 0, 0, 0);
        vecs[16] = mk(VL'(32'h8), VL'(32'h8), 1, Return, 1, 0, 0, 0, 0);
        vecs[17] = mk(VL'(32'h8), VL'(32'h8), 1, NoCF,   1, 0, 0, 0, 0);
        vecs[18] = mk(VL'(32'h20), VL'(32'h20), 1, Branch, 1, 0, 0, 1, 0);
        vecs[19] = mk(VL'(32'h20), VL'(32'h20), 1, Branch, 1, 0, 0, 1, 1);

        // Reset, then the 16-cycle clear.
        tick();
        tick();
        check("rst_init_done", {31'd0, init_done_o}, 32'd0);
        check("rst_pred", {30'd0, bht_prediction_o}, 32'd0);
        rst_i = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            vpc_i = VL'($urandom_range(0, 255));
            check("init_busy", {31'd0, init_done_o}, 32'd0);
            check("init_pred_valid", {31'd0, bht_prediction_o.valid}, 32'd0);
            tick();
        end
        check("init_done", {31'd0, init_done_o}, 32'd1);

        // Training table: one resolve per row, lookup checked the following cycle.
        for (int i = 0; i < 20; i++) begin
            drive_res(vecs[i].rv, vecs[i].pc, vecs[i].cf, vecs[i].tk, vecs[i].mis);
            debug_mode_i = vecs[i].dbg;
            vpc_i        = vecs[i].lpc;
            tick();
            resolved_branch_i.valid = 1'b0;
            debug_mode_i            = 1'b0;
            check($sformatf("row%0d_valid", i), {31'd0, bht_prediction_o.valid}, {31'd0, vecs[i].ev});
            check($sformatf("row%0d_taken", i), {31'd0, bht_prediction_o.taken}, {31'd0, vecs[i].et});
        end

        // Same-cycle training and lookup of an invalid entry.
        drive_res(1'b1, VL'(32'h6), Branch, 1'b1, 1'b0);
        vpc_i = VL'(32'h6);
        #1;
`ifdef BHT_BYPASS_EN
        check("same_cycle_valid", {31'd0, bht_prediction_o.valid}, 32'd1);
        check("same_cycle_taken", {31'd0, bht_prediction_o.taken}, 32'd1);
`else
        check("same_cycle_valid", {31'd0, bht_prediction_o.valid}, 32'd0);
        check("same_cycle_taken", {31'd0, bht_prediction_o.taken}, 32'd0);
`endif
        tick();
        resolved_branch_i.valid = 1'b0;
        check("next_cycle_valid", {31'd0, bht_prediction_o.valid}, 32'd1);
        check("next_cycle_taken", {31'd0, bht_prediction_o.taken}, 32'd1);

        // Flush in RUN together with a trainable resolve: update dropped, table cleared.
        drive_res(1'b1, VL'(32'hA), Branch, 1'b1, 1'b0);
        flush_bp_i = 1'b1;
        tick();
        flush_bp_i              = 1'b0;
        resolved_branch_i.valid = 1'b0;
        wait_clear("run_flush");
        for (int i = 0; i < int'(N); i++) begin
            vpc_i = VL'(i * 2);
            #1;
            check($sformatf("cleared_e%0d", i), {31'd0, bht_prediction_o.valid}, 32'd0);
        end

        // Flush at init cycle 10, with a resolve arriving while still clearing.
        flush_bp_i = 1'b1;
        tick();
        flush_bp_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        flush_bp_i = 1'b1;
        tick();
        flush_bp_i = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (i == 12) drive_res(1'b1, VL'(32'hC), Branch, 1'b1, 1'b0);
            if (i == 13) resolved_branch_i.valid = 1'b0;
            check("mid_init_busy", {31'd0, init_done_o}, 32'd0);
            tick();
        end
        check("mid_init_done", {31'd0, init_done_o}, 32'd1);
        vpc_i = VL'(32'hC);
        #1;
        check("init_resolve_dropped", {31'd0, bht_prediction_o.valid}, 32'd0);

        // Reset while RUN with a trained entry.
        drive_res(1'b1, VL'(32'h8000_0010), Branch, 1'b1, 1'b0);
        vpc_i = VL'(32'h8000_0010);
        tick();
        resolved_branch_i.valid = 1'b0;
        check("pre_rst_valid", {31'd0, bht_prediction_o.valid}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("run_rst_init_done", {31'd0, init_done_o}, 32'd0);
        check("run_rst_pred", {30'd0, bht_prediction_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bht_resolve_unit.md
Name: bht_resolve_unit

Overview:
- Branch history table on the consumer side of the branch-resolution interface.
- Takes resolved branch outcomes (ariane_pkg::bp_resolve_t) from the execute stage and trains per-entry 2-bit saturating counters.
- Serves a direction prediction to the frontend for a lookup PC.
- After reset or a predictor flush, sequentially clears the table over NR_ENTRIES cycles.

Parameters:
- NR_ENTRIES, 1024, number of BHT entries; power of two, >= 4.
- VLEN, riscv::VLEN, virtual address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- flush_bp_i  in  1  flush predictor state; restarts table clear.
- debug_mode_i  in  1  core in debug mode; training suppressed.
- vpc_i  in  VLEN  lookup PC from frontend.
- bht_prediction_o  out  ariane_pkg::bht_prediction_t  {valid, taken} for vpc_i.
- resolved_branch_i  in  ariane_pkg::bp_resolve_t  resolved branch from execute (valid, pc, target_address, is_mispredict, is_taken, cf_type).
- init_done_o  out  1  table clear complete; lookups and training enabled.

Behaviour:
- Clock/reset: one clock clk_i; reset rst_i is synchronous and active-high.
- Indexing: index = pc[$clog2(NR_ENTRIES):1]. Bit 0 is ignored; bit 1 is kept because of compressed instructions. The same function applies to vpc_i and resolved_branch_i.pc.
- Entry format: {valid, cnt[1:0]}. Reset/cleared value is valid=0, cnt=2'b01 (weakly not-taken).
- FSM states: INIT, RUN.
  - rst_i=1 -> INIT, clear_idx=0, init_done_o=0 from the next edge.
  - INIT: each cycle writes the cleared value to entry clear_idx and increments clear_idx. After writing NR_ENTRIES-1, go to RUN the next cycle. The clear takes exactly NR_ENTRIES cycles.
  - RUN: flush_bp_i=1 -> INIT with clear_idx=0.
  - flush_bp_i during INIT restarts with clear_idx=0.
  - rst_i during any state -> INIT with clear_idx=0.
- Lookup: combinational read of the entry at index(vpc_i).
  - bht_prediction_o.valid = entry.valid & init_done_o.
  - bht_prediction_o.taken = cnt[1] & bht_prediction_o.valid.
  - Zero-latency, no handshake.
- Training: occurs on a cycle where all of the following hold:
  - resolved_branch_i.valid;
  - resolved_branch_i.cf_type == ariane_pkg::Branch;
  - !debug_mode_i;
  - state == RUN;
  - !flush_bp_i.
- Training update:
  - Taken: cnt = (cnt==3) ? 3 : cnt+1.
  - Not taken: cnt = (cnt==0) ? 0 : cnt-1.
  - If the entry was invalid, start from cnt=2'b01 before applying the step, then set valid=1.
  - The write is visible at lookup on the next cycle.
- Non-training resolves: resolves with cf_type Jump, JumpR, Return or NoCF are ignored. is_mispredict does not gate training; all conditional branches train.
- Simultaneous events: flush_bp_i or rst_i beats training in the same cycle, and the update is dropped. Resolves arriving in INIT are dropped.
- Same-cycle lookup and update to one index: lookup returns the pre-update value (unless BHT_BYPASS_EN is defined).
- Reset values: bht_prediction_o = '0, init_done_o = 0. Outputs stay 0 until NR_ENTRIES cycles after reset deasserts.
- Storage: flop array. Single write port; the clear write and the training write are mutually exclusive by state.

Optional Feature:
- Macro: BHT_BYPASS_EN.
- Defined: if a training write and a lookup hit the same index in the same cycle, bht_prediction_o reflects the updated entry (valid=1, new cnt[1]). Adds a comparator and a mux on the lookup path.
- Undefined: no bypass; the lookup returns the stored value, and the new value is visible on the next cycle.

Decomposition:
- ariane_pkg additions:
  - bht_entry_t {logic valid; logic [1:0] cnt;}
  - BHT_CNT_RESET = 2'b01
  - function bht_sat_update(cnt, taken).
- bht_prediction_t and bp_resolve_t are reused from ariane_pkg unchanged.
- One natural sub-module: bht_init_sequencer. It holds the INIT/RUN FSM and clear_idx counter, and outputs clear_we, clear_idx and init_done.

Test Plan (NR_ENTRIES=16, index = pc[4:1]):
- Reset clear: rst_i high 2 cycles then low -> init_done_o=0 for 16 cycles, =1 on cycle 17; any vpc_i gives prediction.valid=0.
- Counter training: 3 resolves at pc=0x80000010, cf_type=Branch, is_taken=1 -> after 1st: valid=1, taken=1 (cnt=2); after 3rd cnt=3. Then 1 not-taken -> cnt=2, taken=1. A 2nd not-taken -> cnt=1, taken=0.
- Saturation and aliasing: 5 not-taken at pc=0x20 -> cnt=0. A lookup at pc=0x40 (same index 0) returns identical prediction.
- Filtering: resolve with cf_type=JumpR, or with debug_mode_i=1, at pc=0x8 -> entry 4 stays valid=0.
- Flush mid-init and mid-run:
  - flush_bp_i at init cycle 10 -> init_done_o rises 16 cycles after flush.
  - flush_bp_i in RUN in the same cycle as a valid Branch resolve -> update dropped; all entries read valid=0 after clear.
- Same-cycle hit: update taken at pc=0x6 while vpc_i=0x6 from an invalid entry -> without BHT_BYPASS_EN, prediction.valid=0 that cycle and 1 the next; with it, valid=1, taken=1 that cycle.
